// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider family.
//   state_e      : divider FSM state encoding (IDLE, CALC, DONE)
//   DBZ_QUOTIENT : all-ones quotient reported on divide-by-zero (slice to WIDTH)
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned MAX_WIDTH = 32;

  localparam logic [MAX_WIDTH-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration (combinational).
//   rem_i     : partial remainder before the step (always < divisor_i)
//   bit_i     : next dividend bit shifted into the remainder
//   divisor_i : divisor
//   rem_o     : partial remainder after the step
//   qbit_o    : quotient bit produced by the step
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  // The shifted remainder keeps its carry bit, so the compare and subtract
  // stay exact even when the divisor uses the top bit.
  logic [WIDTH:0] shifted;

  always_comb begin
    shifted = {rem_i, bit_i};
    qbit_o  = (shifted >= {1'b0, divisor_i});
    rem_o   = qbit_o ? WIDTH'(shifted - {1'b0, divisor_i}) : WIDTH'(shifted);
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned divider, one quotient bit per clock, valid/ready on
// both sides.
//   clk, rst_n              : clock, async active-low reset
//   in_valid / in_ready     : operand handshake (in_ready high only in IDLE)
//   dividend, divisor       : operands, captured on the accepting edge
//   out_valid / out_ready   : result handshake
//   quotient, remainder     : result, held until the next result is produced
//   div_by_zero             : result came from a zero divisor
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend bits out the top, quotient bits in the bottom
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;
  logic             ovalid_q, ovalid_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    remo_d   = remo_q;
    dbz_d    = dbz_q;
    ovalid_d = ovalid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d = dividend;
          dvs_d = divisor;
          rem_d = '0;
          cnt_d = CNT_W'(WIDTH);
          if (divisor == '0) begin
            state_d  = DONE;
            quot_d   = DBZ_QUOTIENT[WIDTH-1:0];
            remo_d   = dividend;
            dbz_d    = 1'b1;
            ovalid_d = 1'b1;
          end else begin
            state_d = CALC;
            dbz_d   = 1'b0;
          end
        end
      end
      CALC: begin
        dvd_d = {dvd_q[WIDTH-2:0], step_qbit};
        rem_d = step_rem;
        cnt_d = cnt_q - CNT_W'(1);
        // Final iteration: publish the result on the same edge.
        if (cnt_q == CNT_W'(1)) begin
          state_d  = DONE;
          quot_d   = {dvd_q[WIDTH-2:0], step_qbit};
          remo_d   = step_rem;
          ovalid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d  = IDLE;
          ovalid_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        ovalid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      remo_q   <= '0;
      dbz_q    <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      remo_q   <= remo_d;
      dbz_q    <= dbz_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = ovalid_q;
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks;
  int failures;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, wait for the result, optionally stall, hand off.
  task automatic do_op(input logic [W-1:0] n, input logic [W-1:0] d, input int stall,
                       input bit full_checks);
    logic [W-1:0] eq, er;
    logic         edbz;
    int           exp_cyc, cyc;
    if (d == 0) begin
      eq = '1; er = n; edbz = 1'b1; exp_cyc = 1;
    end else begin
      eq = n / d; er = n % d; edbz = 1'b0; exp_cyc = W + 1;
    end

    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    dividend  = n;
    divisor   = d;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    if (d != 0) begin
      check("dbz_cleared_on_accept", 32'(div_by_zero), 32'd0);
      check("in_ready_busy", 32'(in_ready), 32'd0);
    end

    // cyc = cycles elapsed since the accepting cycle
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      if (full_checks) check("in_ready_calc", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(exp_cyc));

    for (int s = 0; s < stall; s++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_q", 32'(quotient), 32'(eq));
      check("stall_r", 32'(remainder), 32'(er));
      check("stall_in_ready", 32'(in_ready), 32'd0);
      dividend = W'($urandom);
      divisor  = W'($urandom);
      in_valid = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;

    check("quotient", 32'(quotient), 32'(eq));
    check("remainder", 32'(remainder), 32'(er));
    check("div_by_zero", 32'(div_by_zero), 32'(edbz));
    if (d != 0) begin
      check("inv_sum", 32'(quotient) * 32'(d) + 32'(remainder), 32'(n));
      check("inv_rem_lt_div", 32'(remainder < d), 32'd1);
    end

    @(posedge clk); #1;
    check("valid_after_handoff", 32'(out_valid), 32'd0);
    check("in_ready_after_handoff", 32'(in_ready), 32'd1);
    if (full_checks) check("q_retained", 32'(quotient), 32'(eq));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;

    #7;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    #10 rst_n = 1'b1;

    do_op(8'd100, 8'd7,   0, 1'b1);
    do_op(8'd5,   8'd0,   0, 1'b1);
    do_op(8'd9,   8'd3,   0, 1'b1);
    do_op(8'd255, 8'd1,   0, 1'b1);
    do_op(8'd3,   8'd200, 0, 1'b1);
    do_op(8'd255, 8'd255, 0, 1'b1);
    do_op(8'd0,   8'd9,   0, 1'b1);
    do_op(8'd200, 8'd9,   6, 1'b1);

    // Asynchronous reset during the fourth CALC iteration of 77/5.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 8'd77;
    divisor  = 8'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_q", 32'(quotient), 32'd0);
    check("midrst_r", 32'(remainder), 32'd0);
    check("midrst_dbz", 32'(div_by_zero), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_valid", 32'(out_valid), 32'd0);
    do_op(8'd77, 8'd5, 0, 1'b1);

    // Randomized regression with idle gaps and result stalls.
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] rn, rd;
      rn = W'($urandom);
      rd = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(1, 255));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(rn, rd, $urandom_range(0, 3), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
